// File: rtl/add4_accumulator_if.sv
// Handshake and adder-facing bundle for add4_accumulator.
// Valid/ready rule for both streams: a transfer happens on a rising clk edge where valid and ready are both high; a producer holds data steady while valid is high and ready is low.
interface add4_accumulator_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_ovf;

  modport slave (
    input  in_valid, in_data, s, out_ready,
    output in_ready, a, b, out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, in_data, s, out_ready,
    input  in_ready, a, b, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/add4_accumulator.sv
// Streams 4-bit operands through an external 4-bit adder and returns the batch total with a sticky carry flag.
// Optional ADD4_ACC_SAT_EN: saturate the accumulator at 4'hF on carry instead of wrapping.
module add4_accumulator #(
  parameter int COUNT = 4,
  parameter int CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  add4_accumulator_if.slave    bus,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [3:0]    acc;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic          accept;
  logic          carry;
  logic [CW-1:0] cnt_inc;
  logic [3:0]    acc_next;

  assign bus.a         = acc;
  assign bus.b         = bus.in_data;
  assign bus.in_ready  = (state != DONE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;
  assign bus.out_ovf   = ovf;
  assign dbg_state     = state;

  assign accept  = bus.in_valid & bus.in_ready;
  // The adder has no carry-out; a wrapped unsigned sum is always smaller than a.
  assign carry   = (bus.s < acc);
  assign cnt_inc = cnt + CW'(1);

`ifdef ADD4_ACC_SAT_EN
  assign acc_next = carry ? 4'hF : bus.s;
`else
  assign acc_next = bus.s;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 4'h0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_inc;
            if (carry) ovf <= 1'b1;
            state <= (cnt_inc == CW'(COUNT)) ? DONE : ACC;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            acc   <= 4'h0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add4_accumulator.sv
// Directed bench for add4_accumulator: COUNT=4 instance for batches and corner cases, COUNT=1 instance for single-operand batches.
module tb_add4_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  add4_accumulator_if bus4 ();
  add4_accumulator_if bus1 ();
  logic [1:0] dbg4, dbg1;

  // Behavioral stand-in for the gate-level adder.
  assign bus4.s = bus4.a + bus4.b;
  assign bus1.s = bus1.a + bus1.b;

  add4_accumulator #(.COUNT(4), .CW(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4), .dbg_state(dbg4));
  add4_accumulator #(.COUNT(1), .CW(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg1));

`ifdef ADD4_ACC_SAT_EN
  localparam logic [3:0] E_8810 = 4'hF;
  localparam logic [3:0] E_4444 = 4'hF;
  localparam logic [3:0] E_GAP  = 4'hF;
  localparam logic [3:0] E_9900 = 4'hF;
`else
  localparam logic [3:0] E_8810 = 4'h1;
  localparam logic [3:0] E_4444 = 4'h0;
  localparam logic [3:0] E_GAP  = 4'h8;
  localparam logic [3:0] E_9900 = 4'h2;
`endif

  typedef struct {
    logic [3:0] ops [4];
    logic [3:0] exp_data;
    logic       exp_ovf;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q [$];
  logic [3:0] ops_t [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Streams four operands back-to-back into the COUNT=4 instance.
  task automatic send4(input logic [3:0] ops [4]);
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = ops[i];
      chk("in_ready_acc", {7'd0, bus4.in_ready}, 8'd1);
      chk("b_passthrough", {4'd0, bus4.b}, {4'd0, ops[i]});
      step();
    end
    bus4.in_valid = 1'b0;
  endtask

  // Waits (bounded) for a result, compares it with the queue head, then hands it off.
  task automatic collect4(input logic exp_ovf);
    logic [3:0] e;
    int n;
    n = 0;
    while (!bus4.out_valid && n < 8) begin
      step();
      n++;
    end
    chk("out_valid_timeout", {7'd0, bus4.out_valid}, 8'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
    chk("out_data", {4'd0, bus4.out_data}, {4'd0, e});
    chk("out_ovf", {7'd0, bus4.out_ovf}, {7'd0, exp_ovf});
    bus4.out_ready = 1'b1;
    step();
    chk("idle_after_handoff", {6'd0, bus4.out_valid, bus4.in_ready}, 8'd1);
  endtask

  vec_t vecs [6];
  logic [3:0] gap_run [4];

  initial begin
    vecs[0] = '{ops: '{4'd1, 4'd2, 4'd3, 4'd4}, exp_data: 4'hA,   exp_ovf: 1'b0};
    vecs[1] = '{ops: '{4'd8, 4'd8, 4'd1, 4'd0}, exp_data: E_8810, exp_ovf: 1'b1};
    vecs[2] = '{ops: '{4'd4, 4'd4, 4'd4, 4'd4}, exp_data: E_4444, exp_ovf: 1'b1};
    vecs[3] = '{ops: '{4'd0, 4'd0, 4'd0, 4'd0}, exp_data: 4'h0,   exp_ovf: 1'b0};
    vecs[4] = '{ops: '{4'd7, 4'd8, 4'd0, 4'd0}, exp_data: 4'hF,   exp_ovf: 1'b0};
    vecs[5] = '{ops: '{4'd1, 4'd1, 4'd1, 4'd1}, exp_data: 4'h4,   exp_ovf: 1'b0};
    gap_run = '{4'd3, 4'd8, 4'd15, E_GAP};

    rst = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_data = 4'h0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = 4'h0; bus1.out_ready = 1'b0;
    step();
    step();

    // Outputs while reset is held.
    chk("rst_a", {4'd0, bus4.a}, 8'd0);
    chk("rst_in_ready", {7'd0, bus4.in_ready}, 8'd1);
    chk("rst_out_valid", {7'd0, bus4.out_valid}, 8'd0);
    chk("rst_out_data", {4'd0, bus4.out_data}, 8'd0);
    chk("rst_out_ovf", {7'd0, bus4.out_ovf}, 8'd0);
    chk("rst_c1_out_valid", {7'd0, bus1.out_valid}, 8'd0);
    rst = 1'b0;
    step();

    // 1,2,3,4 back-to-back: result exactly one cycle after the last accept.
    bus4.out_ready = 1'b1;
    ops_t = '{4'd1, 4'd2, 4'd3, 4'd4};
    send4(ops_t);
    chk("latency_out_valid", {7'd0, bus4.out_valid}, 8'd1);
    chk("latency_in_ready", {7'd0, bus4.in_ready}, 8'd0);
    chk("latency_out_data", {4'd0, bus4.out_data}, 8'h0A);
    chk("latency_out_ovf", {7'd0, bus4.out_ovf}, 8'd0);
    step();
    chk("back_idle_valid", {7'd0, bus4.out_valid}, 8'd0);
    chk("back_idle_a", {4'd0, bus4.a}, 8'd0);
    bus4.out_ready = 1'b0;

    // Table of batches.
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].exp_data);
      send4(vecs[v].ops);
      collect4(vecs[v].exp_ovf);
      bus4.out_ready = 1'b0;
    end

    // 3,5,7,9 with two-cycle gaps; a must hold and in_data may wander.
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = (i == 0) ? 4'd3 : (i == 1) ? 4'd5 : (i == 2) ? 4'd7 : 4'd9;
      step();
      bus4.in_valid = 1'b0;
      if (i < 3) begin
        for (int g = 0; g < 2; g++) begin
          bus4.in_data = 4'($urandom_range(0, 15));
          step();
          chk("gap_a_hold", {4'd0, bus4.a}, {4'd0, gap_run[i]});
        end
      end
    end
    exp_q.push_back(E_GAP);
    collect4(1'b1);
    bus4.out_ready = 1'b0;

    // Result held with out_ready low; in_valid must not be accepted.
    ops_t = '{4'd9, 4'd9, 4'd0, 4'd0};
    send4(ops_t);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 4'd5;
    for (int k = 0; k < 3; k++) begin
      chk("hold_out_valid", {7'd0, bus4.out_valid}, 8'd1);
      chk("hold_in_ready", {7'd0, bus4.in_ready}, 8'd0);
      chk("hold_out_data", {4'd0, bus4.out_data}, {4'd0, E_9900});
      chk("hold_out_ovf", {7'd0, bus4.out_ovf}, 8'd1);
      step();
    end
    bus4.out_ready = 1'b1;
    step();
    bus4.in_valid = 1'b0;
    chk("handoff_out_valid", {7'd0, bus4.out_valid}, 8'd0);
    chk("handoff_ovf_clear", {7'd0, bus4.out_ovf}, 8'd0);
    chk("handoff_a_clear", {4'd0, bus4.a}, 8'd0);
    bus4.out_ready = 1'b0;
    ops_t = '{4'd1, 4'd1, 4'd1, 4'd1};
    exp_q.push_back(4'h4);
    send4(ops_t);
    collect4(1'b0);
    bus4.out_ready = 1'b0;

    // Reset mid-batch after 6,6.
    for (int i = 0; i < 2; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 4'd6;
      step();
    end
    bus4.in_valid = 1'b0;
    chk("pre_rst_a", {4'd0, bus4.a}, 8'd12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_a", {4'd0, bus4.a}, 8'd0);
    chk("midrst_in_ready", {7'd0, bus4.in_ready}, 8'd1);
    chk("midrst_out_valid", {7'd0, bus4.out_valid}, 8'd0);
    ops_t = '{4'd1, 4'd1, 4'd1, 4'd1};
    exp_q.push_back(4'h4);
    send4(ops_t);
    collect4(1'b0);
    bus4.out_ready = 1'b0;

    // COUNT=1: single operand 0xF completes the batch.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 4'hF;
    chk("c1_in_ready", {7'd0, bus1.in_ready}, 8'd1);
    step();
    bus1.in_valid = 1'b0;
    chk("c1_out_valid", {7'd0, bus1.out_valid}, 8'd1);
    chk("c1_out_data", {4'd0, bus1.out_data}, 8'h0F);
    chk("c1_out_ovf", {7'd0, bus1.out_ovf}, 8'd0);
    chk("c1_in_ready_done", {7'd0, bus1.in_ready}, 8'd0);
    bus1.out_ready = 1'b1;
    step();
    chk("c1_idle", {6'd0, bus1.out_valid, bus1.in_ready}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
